arbitro_terminais: RTL

- Clocked, parametrised successor to the two-user combinational access path: N_CANAIS user channels each submit a request carrying a user code, a function code and a target terminal.
- Each request is checked against a permission rule, then arbitrated round-robin per terminal.
- The winning function is latched onto that terminal for a fixed session time.
- Sits between the user input stage and the terminal decoders (matrix, LEDs, 7-seg), replacing the fixed two-user demux/mux steering.

---
 rtl/pkg_controle_acesso.sv | 31 +++
 rtl/controle_terminal.sv | 112 +++++++++++
 rtl/arbitro_terminais.sv | 88 ++++++++
 3 files changed

// File: rtl/pkg_controle_acesso.sv
// rtl/pkg_controle_acesso.sv - shared types, widths and permission rule for the terminal arbiter
package pkg_controle_acesso;

    localparam int unsigned FUNC_NENHUMA    = 0;
    // Widest packed channel bus the slice helper can take.
    localparam int unsigned LARG_BARRAMENTO = 256;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } estado_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int larg_bits(input int n);
        return max_int(1, $clog2(n));
    endfunction

    function automatic logic perm_ok(input logic [31:0] usr, input logic [31:0] func,
                                     input logic [31:0] tsel, input int n_term);
        return (func != FUNC_NENHUMA) && (func <= usr) && (tsel < n_term);
    endfunction

    function automatic logic [31:0] fatia(input logic [LARG_BARRAMENTO-1:0] bus,
                                          input int unsigned idx, input int unsigned w);
        return 32'((bus >> (idx * w)) & ~({LARG_BARRAMENTO{1'b1}} << w));
    endfunction

endpackage

// File: rtl/controle_terminal.sv
// rtl/controle_terminal.sv - per-terminal session FSM with round-robin grant and hold counter
module controle_terminal
    import pkg_controle_acesso::*;
#(
    parameter int N_CANAIS    = 2,
    parameter int W_FUNC      = 3,
    parameter int HOLD_CICLOS = 8,
    localparam int CW         = larg_bits(N_CANAIS),
    localparam int WC         = $clog2(HOLD_CICLOS + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_CANAIS-1:0]        cand,
    input  logic [N_CANAIS*W_FUNC-1:0] func_bus,
    output logic [N_CANAIS-1:0]        gnt,
    output logic                       t_valid,
    output logic [W_FUNC-1:0]          t_func,
    output logic [CW-1:0]              t_owner
);

    localparam logic [WC-1:0] RECARGA = WC'(HOLD_CICLOS - 1);
    localparam logic [CW-1:0] PTR_INI = CW'(N_CANAIS - 1);

    estado_t             estado_q, estado_d;
    logic [WC-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       owner_q, owner_d;
    logic [N_CANAIS-1:0] gnt_q, gnt_d;
    logic                valid_q, valid_d;
    logic [W_FUNC-1:0]   func_q, func_d;
    logic [CW-1:0]       cand_idx, vencedor;
    logic                achou;

    // First candidate strictly after the pointer, wrapping at N_CANAIS.
    always_comb begin
        achou    = 1'b0;
        vencedor = '0;
        cand_idx = '0;
        for (int k = 1; k <= N_CANAIS; k++) begin
            cand_idx = CW'((int'(ptr_q) + k) % N_CANAIS);
            if (!achou && cand[cand_idx]) begin
                achou    = 1'b1;
                vencedor = cand_idx;
            end
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        gnt_d    = '0;
        valid_d  = valid_q;
        func_d   = func_q;
        case (estado_q)
            IDLE: begin
                if (achou) begin
                    gnt_d[vencedor] = 1'b1;
                    func_d          = func_bus[vencedor*W_FUNC +: W_FUNC];
                    owner_d         = vencedor;
                    valid_d         = 1'b1;
                    cnt_d           = RECARGA;
                    ptr_d           = vencedor;
                    estado_d        = BUSY;
                end
            end
            BUSY: begin
                // Owner refresh wins over expiry in the same cycle.
                if (cand[owner_q]) begin
                    gnt_d[owner_q] = 1'b1;
                    func_d         = func_bus[owner_q*W_FUNC +: W_FUNC];
                    cnt_d          = RECARGA;
                end else if (cnt_q == '0) begin
                    valid_d  = 1'b0;
                    func_d   = '0;
                    owner_d  = '0;
                    estado_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= PTR_INI;
            owner_q  <= '0;
            gnt_q    <= '0;
            valid_q  <= 1'b0;
            func_q   <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            valid_q  <= valid_d;
            func_q   <= func_d;
        end
    end

    assign gnt     = gnt_q;
    assign t_valid = valid_q;
    assign t_func  = func_q;
    assign t_owner = owner_q;

endmodule

// File: rtl/arbitro_terminais.sv
// rtl/arbitro_terminais.sv - permission check and per-terminal round-robin session arbiter
module arbitro_terminais
    import pkg_controle_acesso::*;
#(
    parameter int N_CANAIS    = 2,
    parameter int N_TERMINAIS = 2,
    parameter int W_USR       = 3,
    parameter int W_FUNC      = 3,
    parameter int HOLD_CICLOS = 8,
    localparam int CW         = larg_bits(N_CANAIS),
    localparam int TW         = larg_bits(N_TERMINAIS)
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [N_CANAIS-1:0]           REQ,
    input  logic [N_CANAIS*W_USR-1:0]     USR,
    input  logic [N_CANAIS*W_FUNC-1:0]    FUNC,
    input  logic [N_CANAIS*TW-1:0]        TSEL,
    output logic [N_CANAIS-1:0]           GNT,
    output logic [N_CANAIS-1:0]           DENY,
    output logic [N_TERMINAIS-1:0]        T_VALID,
    output logic [N_TERMINAIS*W_FUNC-1:0] T_FUNC,
    output logic [N_TERMINAIS*CW-1:0]     T_OWNER
);

    logic [W_USR-1:0]    usr_c  [N_CANAIS];
    logic [W_FUNC-1:0]   func_c [N_CANAIS];
    logic [TW-1:0]       tsel_c [N_CANAIS];
    logic [N_CANAIS-1:0] perm;
    logic [N_CANAIS-1:0] deny_d, deny_q;
    logic [N_CANAIS-1:0] cand   [N_TERMINAIS];
    logic [N_CANAIS-1:0] gnt_t  [N_TERMINAIS];
    logic [N_CANAIS-1:0] gnt_or;

    for (genvar i = 0; i < N_CANAIS; i++) begin : g_canal
        assign usr_c[i]  = W_USR'(fatia(LARG_BARRAMENTO'(USR), i, W_USR));
        assign func_c[i] = W_FUNC'(fatia(LARG_BARRAMENTO'(FUNC), i, W_FUNC));
        assign tsel_c[i] = TW'(fatia(LARG_BARRAMENTO'(TSEL), i, TW));
        assign perm[i]   = perm_ok(32'(usr_c[i]), 32'(func_c[i]), 32'(tsel_c[i]), N_TERMINAIS);
    end

    // Refused requests are filtered here and never reach any terminal.
    always_comb begin
        deny_d = REQ & ~perm;
        cand   = '{default: '0};
        for (int t = 0; t < N_TERMINAIS; t++) begin
            for (int i = 0; i < N_CANAIS; i++) begin
                cand[t][i] = REQ[i] & perm[i] & (tsel_c[i] == TW'(t));
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            deny_q <= '0;
        end else begin
            deny_q <= deny_d;
        end
    end

    for (genvar t = 0; t < N_TERMINAIS; t++) begin : g_term
        controle_terminal #(
            .N_CANAIS    (N_CANAIS),
            .W_FUNC      (W_FUNC),
            .HOLD_CICLOS (HOLD_CICLOS)
        ) u_terminal (
            .clk      (CLK),
            .rst_n    (RST_N),
            .cand     (cand[t]),
            .func_bus (FUNC),
            .gnt      (gnt_t[t]),
            .t_valid  (T_VALID[t]),
            .t_func   (T_FUNC[t*W_FUNC +: W_FUNC]),
            .t_owner  (T_OWNER[t*CW +: CW])
        );
    end

    always_comb begin
        gnt_or = '0;
        for (int t = 0; t < N_TERMINAIS; t++) begin
            gnt_or = gnt_or | gnt_t[t];
        end
    end

    assign GNT  = gnt_or;
    assign DENY = deny_q;

endmodule
